// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants and types for the PS/2 key sequencing
//               controller: the break/extended prefix bytes and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } ps2_ctrl_state_t;

endpackage : ps2_pkg

`default_nettype wire

// File: rtl/ps2_code_decode.sv
// ============================================================================
// Module      : ps2_code_decode
// Description : Combinational classifier for one scan-code byte given the
//               pending prefix flags and the currently held key.
// Ports       : i_byte        - byte being decoded
//               i_brk_pend    - break prefix seen before this byte
//               i_ext_pend    - extended prefix seen before this byte
//               i_key_code    - {ext, scan code} of the held / last key
//               i_key_down    - a key is currently held
//               o_is_prefix   - byte is F0 or E0
//               o_is_release_match - byte releases the held key
//               o_is_new_press     - byte is a make code of a new key
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_code_decode
    import ps2_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_brk_pend,
    input  logic       i_ext_pend,
    input  logic [8:0] i_key_code,
    input  logic       i_key_down,
    output logic       o_is_prefix,
    output logic       o_is_release_match,
    output logic       o_is_new_press
);

    logic [8:0] w_code;
    logic       w_same_key;

    assign w_code     = {i_ext_pend, i_byte};
    assign w_same_key = (w_code == i_key_code);

    // E0 counts as a prefix even when extended tracking is off, so that it
    // is always consumed without being mistaken for a make code.
    assign o_is_prefix        = (i_byte == PS2_BREAK) || (i_byte == PS2_EXT);
    assign o_is_release_match = !o_is_prefix && i_brk_pend && i_key_down && w_same_key;
    assign o_is_new_press     = !o_is_prefix && !i_brk_pend && (!i_key_down || !w_same_key);

endmodule : ps2_code_decode

`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
// ============================================================================
// Module      : ps2_key_ctrl
// Description : Pops scan-code bytes from the PS/2 receiver FIFO, decodes
//               break/extended prefixes, tracks the held key, suppresses
//               typematic repeats and counts distinct presses.
// Config      : PS2_EXT_EN - when defined, E0 prefixes are tracked and
//               o_key_code[8] carries the extended bit; otherwise E0 bytes
//               are discarded and extended keys alias onto base codes.
// Ports       : clk, rst (async, active-high)
//               i_kb_data / i_kb_ready / i_kb_overflow - receiver FIFO side
//               o_kb_nextdata_n - active-low pop strobe
//               o_key_code, o_key_down, o_key_count - key state
//               o_press_pulse, o_release_pulse - one-cycle event pulses
//               o_ovf_err - sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_kb_data,
    input  logic             i_kb_ready,
    input  logic             i_kb_overflow,
    output logic             o_kb_nextdata_n,
    output logic [8:0]       o_key_code,
    output logic             o_key_down,
    output logic [CNT_W-1:0] o_key_count,
    output logic             o_press_pulse,
    output logic             o_release_pulse,
    output logic             o_ovf_err
);

    ps2_ctrl_state_t r_state;
    ps2_ctrl_state_t w_next;

    logic [7:0]       r_byte;
    logic             r_brk_pend;
    logic             w_ext_pend;
    logic [8:0]       r_key_code;
    logic             r_key_down;
    logic [CNT_W-1:0] r_key_count;
    logic             r_press;
    logic             r_release;
    logic             r_ovf_err;
    logic             r_nextdata_n;

    logic w_pop;
    logic w_is_prefix;
    logic w_is_release_match;
    logic w_is_new_press;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_kb_ready) w_next = S_POP;
            S_POP:    w_next = S_SETTLE;
            S_SETTLE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_pop = (r_state == S_POP);

    ps2_code_decode u_decode (
        .i_byte             (r_byte),
        .i_brk_pend         (r_brk_pend),
        .i_ext_pend         (w_ext_pend),
        .i_key_code         (r_key_code),
        .i_key_down         (r_key_down),
        .o_is_prefix        (w_is_prefix),
        .o_is_release_match (w_is_release_match),
        .o_is_new_press     (w_is_new_press)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte       <= 8'h00;
            r_brk_pend   <= 1'b0;
            r_key_code   <= 9'h000;
            r_key_down   <= 1'b0;
            r_key_count  <= '0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_nextdata_n <= 1'b1;
        end else begin
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            // Strobe is registered so it is low exactly while in S_POP.
            r_nextdata_n <= !(w_next == S_POP);

            if (i_kb_overflow) begin
                r_ovf_err <= 1'b1;
            end

            if (r_state == S_IDLE && i_kb_ready) begin
                r_byte <= i_kb_data;
            end

            if (w_pop) begin
                if (r_byte == PS2_BREAK) begin
                    r_brk_pend <= 1'b1;
                end else if (w_is_prefix) begin
                    // E0: extended flag handled below; nothing else changes.
                end else if (r_brk_pend) begin
                    r_brk_pend <= 1'b0;
                    if (w_is_release_match) begin
                        r_key_down <= 1'b0;
                        r_release  <= 1'b1;
                    end
                end else if (w_is_new_press) begin
                    r_key_code  <= {w_ext_pend, r_byte};
                    r_key_down  <= 1'b1;
                    r_press     <= 1'b1;
                    r_key_count <= r_key_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef PS2_EXT_EN
    logic r_ext_pend;

    // Set on E0, cleared by any non-prefix byte; survives an F0 so that
    // E0 F0 xx releases the extended key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_pend <= 1'b0;
        end else if (w_pop) begin
            if (r_byte == PS2_EXT) begin
                r_ext_pend <= 1'b1;
            end else if (!w_is_prefix) begin
                r_ext_pend <= 1'b0;
            end
        end
    end

    assign w_ext_pend = r_ext_pend;
`else
    assign w_ext_pend = 1'b0;
`endif

    assign o_kb_nextdata_n = r_nextdata_n;
    assign o_key_code      = r_key_code;
    assign o_key_down      = r_key_down;
    assign o_key_count     = r_key_count;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_ovf_err       = r_ovf_err;

endmodule : ps2_key_ctrl

`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
// ============================================================================
// Module      : tb_ps2_key_ctrl
// Description : Self-checking bench for ps2_key_ctrl. A byte queue stands in
//               for the receiver FIFO; a byte-level reference model predicts
//               key state and pulses after every pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_ctrl;

    localparam int CNT_W = 8;
`ifdef PS2_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       i_kb_data = 8'h00;
    logic             i_kb_ready = 1'b0;
    logic             i_kb_overflow = 1'b0;
    logic             o_kb_nextdata_n;
    logic [8:0]       o_key_code;
    logic             o_key_down;
    logic [CNT_W-1:0] o_key_count;
    logic             o_press_pulse;
    logic             o_release_pulse;
    logic             o_ovf_err;

    ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_kb_data       (i_kb_data),
        .i_kb_ready      (i_kb_ready),
        .i_kb_overflow   (i_kb_overflow),
        .o_kb_nextdata_n (o_kb_nextdata_n),
        .o_key_code      (o_key_code),
        .o_key_down      (o_key_down),
        .o_key_count     (o_key_count),
        .o_press_pulse   (o_press_pulse),
        .o_release_pulse (o_release_pulse),
        .o_ovf_err       (o_ovf_err)
    );

    always #5 clk = ~clk;

    // Receiver FIFO stand-in and reference model state
    logic [7:0] q[$];
    bit         pop_pend, nd_prev_low, ovf_drv, ovf_next;
    bit         m_brk, m_ext, m_down, e_press, e_rel, e_ovf;
    logic [8:0] m_code;
    int         m_cnt;
    int         idle_wait;
    int         n_press, n_rel;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_brk = 0; m_ext = 0; m_down = 0; m_code = 9'h000; m_cnt = 0;
        e_press = 0; e_rel = 0; e_ovf = 0;
    endfunction

    // Scan-code semantics: F0 = break prefix, E0 = extended prefix,
    // anything else completes a make or break for the key it names.
    function automatic void model_byte(input logic [7:0] b);
        logic [8:0] code;
        code = {m_ext, b};
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            if (EXT) m_ext = 1;
        end else if (m_brk) begin
            if (m_down && code == m_code) begin
                m_down = 0;
                e_rel  = 1;
            end
            m_brk = 0;
            m_ext = 0;
        end else begin
            if (!m_down || code != m_code) begin
                m_code  = code;
                m_down  = 1;
                e_press = 1;
                m_cnt   = (m_cnt + 1) % (1 << CNT_W);
            end
            m_ext = 0;
        end
    endfunction

    // One clock cycle: update model/FIFO just after the edge, drive inputs,
    // then check outputs on the falling edge.
    task automatic cyc_r(input bit drop_rst);
        @(posedge clk);
        #1;
        e_press = 0;
        e_rel   = 0;
        if (!rst) begin
            if (ovf_drv) e_ovf = 1;
            if (pop_pend) begin
                model_byte(q[0]);
                void'(q.pop_front());
            end
        end
        pop_pend = 0;
        if (drop_rst) rst = 1'b0;
        i_kb_overflow = ovf_next;
        ovf_drv       = ovf_next;
        ovf_next      = 0;
        i_kb_ready    = (q.size() > 0);
        i_kb_data     = (q.size() > 0) ? q[0] : 8'h00;
        @(negedge clk);
        chk("key_code", o_key_code, m_code);
        chk("key_down", o_key_down, m_down);
        chk("key_count", o_key_count, m_cnt);
        chk("press_pulse", o_press_pulse, e_press);
        chk("release_pulse", o_release_pulse, e_rel);
        chk("ovf_err", o_ovf_err, e_ovf);
        if (rst) begin
            chk("nextdata_in_reset", o_kb_nextdata_n, 1);
        end else begin
            if (!o_kb_nextdata_n) begin
                chk("nextdata_double_low", nd_prev_low, 0);
                chk("pop_from_empty", q.size() > 0, 1);
                if (q.size() > 0) pop_pend = 1;
            end
            if (q.size() > 0 && o_kb_nextdata_n) idle_wait++;
            else idle_wait = 0;
            if (idle_wait > 4) chk("pop_stall", idle_wait, 4);
        end
        nd_prev_low = !o_kb_nextdata_n;
        if (o_press_pulse)   n_press++;
        if (o_release_pulse) n_rel++;
    endtask

    task automatic cyc();
        cyc_r(1'b0);
    endtask

    task automatic do_reset(input bit clear_q);
        rst = 1'b1;
        pop_pend = 0; nd_prev_low = 0; ovf_drv = 0; ovf_next = 0; idle_wait = 0;
        model_reset();
        if (clear_q) q.delete();
        cyc();
        cyc();
        cyc_r(1'b1);
        n_press = 0;
        n_rel   = 0;
    endtask

    task automatic drain();
        int lim;
        lim = 4 * q.size() + 12;
        while ((q.size() > 0 || pop_pend) && lim > 0) begin
            cyc();
            lim--;
        end
        if (lim == 0) chk("drain_timeout", q.size(), 0);
        repeat (3) cyc();
    endtask

    typedef struct {
        logic [7:0] b[6];
        int         n;
        logic [8:0] code;
        bit         down;
        int         cnt;
        int         np;
        int         nr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // ---- Directed sequences with independently stated outcomes ----
        tbl[0] = '{b:'{8'h1C,8'hF0,8'h1C,8'h00,8'h00,8'h00}, n:3, code:9'h01C, down:0, cnt:1, np:1, nr:1};
        tbl[1] = '{b:'{8'h1C,8'h1C,8'h1C,8'hF0,8'h1C,8'h00}, n:5, code:9'h01C, down:0, cnt:1, np:1, nr:1};
        tbl[2] = '{b:'{8'h1C,8'h32,8'hF0,8'h1C,8'h00,8'h00}, n:4, code:9'h032, down:1, cnt:2, np:2, nr:0};
        if (EXT) begin
            tbl[3] = '{b:'{8'hE0,8'h75,8'hE0,8'hF0,8'h75,8'h00}, n:5, code:9'h175, down:0, cnt:1, np:1, nr:1};
            tbl[4] = '{b:'{8'hE0,8'h75,8'h75,8'h00,8'h00,8'h00}, n:3, code:9'h075, down:1, cnt:2, np:2, nr:0};
        end else begin
            tbl[3] = '{b:'{8'hE0,8'h75,8'hE0,8'hF0,8'h75,8'h00}, n:5, code:9'h075, down:0, cnt:1, np:1, nr:1};
            tbl[4] = '{b:'{8'hE0,8'h75,8'h75,8'h00,8'h00,8'h00}, n:3, code:9'h075, down:1, cnt:1, np:1, nr:0};
        end

        // ---- Reset with ready held high, then first pop timing ----
        q.delete();
        q.push_back(8'h1C);
        rst = 1'b1;
        pop_pend = 0; nd_prev_low = 0; ovf_drv = 0; ovf_next = 0; idle_wait = 0;
        model_reset();
        cyc();
        cyc();
        cyc_r(1'b1);
        chk("first_pop_not_yet", o_kb_nextdata_n, 1);
        cyc();
        chk("first_pop", o_kb_nextdata_n, 0);
        drain();
        chk("first_byte_code", o_key_code, 9'h01C);

        // ---- Table-driven sequences ----
        for (int t = 0; t < 5; t++) begin
            do_reset(1'b1);
            for (int k = 0; k < tbl[t].n; k++) q.push_back(tbl[t].b[k]);
            drain();
            chk($sformatf("vec%0d_code", t), o_key_code, tbl[t].code);
            chk($sformatf("vec%0d_down", t), o_key_down, tbl[t].down);
            chk($sformatf("vec%0d_count", t), o_key_count, tbl[t].cnt);
            chk($sformatf("vec%0d_npress", t), n_press, tbl[t].np);
            chk($sformatf("vec%0d_nrel", t), n_rel, tbl[t].nr);
        end

        // ---- Reset mid-handshake: byte stays in FIFO and is reprocessed ----
        do_reset(1'b1);
        q.push_back(8'h1C);
        begin
            int lim;
            lim = 10;
            while (!pop_pend && lim > 0) begin
                cyc();
                lim--;
            end
            chk("midrst_saw_pop", pop_pend, 1);
        end
        do_reset(1'b0);
        chk("midrst_byte_kept", q.size(), 1);
        drain();
        chk("midrst_count", o_key_count, 1);
        chk("midrst_npress", n_press, 1);

        // ---- Counter wrap after 256 distinct presses ----
        do_reset(1'b1);
        for (int k = 0; k < 256; k++) q.push_back((k % 2) ? 8'h32 : 8'h1C);
        drain();
        chk("wrap_count", o_key_count, 0);
        chk("wrap_npress", n_press, 256);

        // ---- Sticky overflow ----
        do_reset(1'b1);
        ovf_next = 1;
        repeat (6) cyc();
        chk("ovf_sticky", o_ovf_err, 1);
        do_reset(1'b1);
        chk("ovf_cleared", o_ovf_err, 0);

        // ---- Randomized traffic against the model ----
        do_reset(1'b1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && q.size() < 8) begin
                case ($urandom_range(0, 6))
                    0:       q.push_back(8'h1C);
                    1:       q.push_back(8'h32);
                    2:       q.push_back(8'h75);
                    3:       q.push_back(8'hF0);
                    4:       q.push_back(8'hE0);
                    5:       q.push_back(8'h75);
                    default: q.push_back(8'($urandom));
                endcase
            end
            if ($urandom_range(0, 60) == 0) ovf_next = 1;
            cyc();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_ps2_key_ctrl

`default_nettype wire
